fp_add_post_normalize: RTL and testbench



---
 rtl/fp_add_post_normalize.sv | 147 ++++++++++++++
 tb/tb_fp_add_post_normalize.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_add_post_normalize.sv
// Post-adder normalizer and rounder for the single-precision add/sub path.
// It normalizes the raw sum one bit per cycle, rounds to nearest-even, and
// packs an IEEE-754 word with {overflow, underflow, inexact, zero} flags.
module fp_add_post_normalize #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int MANT_W = FRAC_W + 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [MANT_W-1:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic [3:0]                out_flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One spare exponent bit so that a carry out of 0xFF is visible as overflow.
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  logic [1:0]              state;
  logic                    sign_q;
  logic [EXP_W:0]          exp_q;
  logic [MANT_W-1:0]       mant_q;
  logic [EXP_W+FRAC_W:0]   result_q;
  logic [3:0]              flags_q;

  // Rounding datapath signals.
  logic                    rnd_inc;
  logic                    rnd_inexact;
  logic [FRAC_W+1:0]       rnd_sum;
  logic [EXP_W:0]          rnd_exp;
  logic [FRAC_W-1:0]       rnd_frac;
  logic [EXP_W+FRAC_W:0]   rnd_result;
  logic [3:0]              rnd_flags;

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

  // Round-to-nearest-even on the normalized mantissa held in mant_q.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    rnd_exp     = exp_q;
    rnd_frac    = '0;
    rnd_result  = '0;
    rnd_flags   = '0;
    rnd_inexact = |mant_q[2:0];
    rnd_inc     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_sum     = {1'b0, mant_q[MANT_W-2:3]} + (FRAC_W+2)'(rnd_inc);

    if (rnd_sum[FRAC_W+1]) begin
      // Increment rippled past the hidden bit: renormalize right by one.
      rnd_exp  = exp_q + EXP_ONE;
      rnd_frac = rnd_sum[FRAC_W:1];
    end else begin
      rnd_frac = rnd_sum[FRAC_W-1:0];
    end

    if (rnd_exp >= EXP_MAX) begin
      rnd_result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rnd_flags  = 4'b1010;
    end else begin
      rnd_result = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
      rnd_flags  = {2'b00, rnd_inexact, 1'b0};
    end
  end

  // Control FSM plus the working sign/exponent/mantissa and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= {1'b0, in_exp};
            mant_q <= in_mant;
            state  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (exp_q == EXP_MAX) begin
            // Inf/NaN operand: pass the fraction through untouched.
            result_q <= {sign_q, {EXP_W{1'b1}}, mant_q[MANT_W-3:3]};
            flags_q  <= 4'b0000;
            state    <= S_DONE;
          end else if (mant_q == '0) begin
            result_q <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
            flags_q  <= 4'b0001;
            state    <= S_DONE;
          end else if (mant_q[MANT_W-1]) begin
            // Carry out of the adder: shift right, folding bit 1 into sticky.
            mant_q <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXP_ONE;
            state  <= S_ROUND;
          end else if (mant_q[MANT_W-2]) begin
            state <= S_ROUND;
          end else if (exp_q <= EXP_ONE) begin
            // No room left to normalize: flush to signed zero.
            result_q <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
            flags_q  <= 4'b0110;
            state    <= S_DONE;
          end else begin
            mant_q <= {mant_q[MANT_W-2:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end
        end

        S_ROUND: begin
          result_q <= rnd_result;
          flags_q  <= rnd_flags;
          state    <= S_DONE;
        end

        default: begin
          // S_DONE: result held until the consumer takes it.
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_post_normalize.sv
// Self-checking bench for fp_add_post_normalize: a table of vectors with
// expected word, flags and latency, a scoreboard queue, plus hand-written
// sequences for output back-pressure and mid-operation reset.
module tb_fp_add_post_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [31:0] result;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[15];

  fp_add_post_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one operand, wait for the result, compare against the scoreboard,
  // optionally stall the consumer for 'hold' cycles, then hand it off.
  task automatic run_vec(input vec_t v, input int hold, input string name);
    exp_t e;
    int   n;
    logic [31:0] held;
    @(negedge clk);
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    sb_q.push_back('{v.result, v.flags, v.lat});
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    if (!out_valid) begin
      check({name, " timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    check({name, " result"}, out_result, e.result);
    check({name, " flags"}, 32'(out_flags), 32'(e.flags));
    check({name, " latency"}, 32'(n), 32'(e.lat));
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold valid"}, 32'(out_valid), 32'd1);
      check({name, " hold result"}, out_result, held);
      check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid drop"}, 32'(out_valid), 32'd0);
    check({name, " result retained"}, out_result, held);
  endtask

  initial begin
    vec_t one;
    int   seen;

    //           sign  exp     mant           result         flags    lat
    vecs[0]  = '{1'b0, 8'h7F, 28'h4000000, 32'h3F800000, 4'b0000, 3};
    vecs[1]  = '{1'b0, 8'h7F, 28'h8000000, 32'h40000000, 4'b0000, 3};
    vecs[2]  = '{1'b0, 8'h80, 28'h0800000, 32'h3E800000, 4'b0000, 6};
    vecs[3]  = '{1'b0, 8'h7F, 28'h4000007, 32'h3F800001, 4'b0010, 3};
    vecs[4]  = '{1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 4'b0010, 3};
    vecs[5]  = '{1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 4'b0010, 3};
    vecs[6]  = '{1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 4'b1010, 3};
    vecs[7]  = '{1'b0, 8'h02, 28'h0000008, 32'h00000000, 4'b0110, 3};
    vecs[8]  = '{1'b0, 8'h7F, 28'h8000009, 32'h40000001, 4'b0010, 3};
    vecs[9]  = '{1'b0, 8'hFF, 28'h4000008, 32'h7F800001, 4'b0000, 2};
    vecs[10] = '{1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 4'b1010, 3};
    vecs[11] = '{1'b0, 8'h01, 28'h4000000, 32'h00800000, 4'b0000, 3};
    vecs[12] = '{1'b1, 8'h01, 28'h2000000, 32'h80000000, 4'b0110, 2};
    vecs[13] = '{1'b1, 8'h85, 28'h4000000, 32'hC2800000, 4'b0000, 3};
    vecs[14] = '{1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 4'b0010, 3};

    // Reset state.
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_result", out_result, 32'd0);
    check("reset out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Negative zero with the consumer stalled for five cycles.
    run_vec('{1'b1, 8'h7F, 28'h0000000, 32'h80000000, 4'b0001, 2}, 5, "neg_zero_hold");

    // Reset in the middle of a 10-shift normalization.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h90;
    in_mant  = 28'h0010000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-shift in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_result", out_result, 32'd0);
    check("abort out_flags", 32'(out_flags), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("aborted op silent", 32'(seen), 32'd0);
    one = '{1'b0, 8'h7F, 28'h4000000, 32'h3F800000, 4'b0000, 3};
    run_vec(one, 0, "after_reset_one");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
